// File: rtl/fd_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// fd_control_unit_pkg
// Shared definitions for the FD control unit: RV64 opcode / funct3 / funct7
// constants for the supported subset (ld, sd, add, sub), the FSM state
// encoding, the instruction-kind encoding and the wait-counter limits.
// -----------------------------------------------------------------------------
package fd_control_unit_pkg;

    // Major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // funct3 / funct7 values
    localparam logic [2:0] F3_DWORD   = 3'b011;
    localparam logic [2:0] F3_ADDSUB  = 3'b000;
    localparam logic [6:0] F7_ADD     = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

    // Memory settle counter
    localparam int WAIT_CNT_W   = 4;
    localparam int MEM_WAIT_MAX = 15;

    // Control FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_WAIT   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } fd_state_e;

    // Decoded instruction class; KIND_NONE marks an unsupported encoding
    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_LD   = 2'd1,
        KIND_SD   = 2'd2,
        KIND_ALU  = 2'd3
    } fd_kind_e;

    // Classify an instruction word into one of the supported kinds.
    function automatic fd_kind_e classify(input logic [31:0] w);
        fd_kind_e k;
        k = KIND_NONE;
        case (w[6:0])
            OPC_LOAD: begin
                if (w[14:12] == F3_DWORD) k = KIND_LD;
                else                      k = KIND_NONE;
            end
            OPC_STORE: begin
                if (w[14:12] == F3_DWORD) k = KIND_SD;
                else                      k = KIND_NONE;
            end
            OPC_OP: begin
                if ((w[14:12] == F3_ADDSUB) &&
                    ((w[31:25] == F7_ADD) || (w[31:25] == F7_SUB)))
                    k = KIND_ALU;
                else
                    k = KIND_NONE;
            end
            default: k = KIND_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/fd_control_unit_instr_decoder.sv
// -----------------------------------------------------------------------------
// fd_control_unit_instr_decoder
// Purely combinational decoder: instruction word -> datapath control fields.
// Fields that an instruction does not use are driven 0; an unsupported
// encoding drives every field 0 and raises illegal_o.
// Ports:
//   instr_i    32-bit instruction word
//   ra_o       rs1 (ALU A / address base)
//   rb_o       rs2 (ALU B / store data)
//   rw_o       rd  (register write address)
//   offset_o   sign-extended immediate
//   op_mem_o   1 = memory access
//   add_sub_o  1 = subtract
//   kind_o     decoded instruction class
//   illegal_o  unsupported encoding
// -----------------------------------------------------------------------------
module fd_control_unit_instr_decoder
    import fd_control_unit_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int DATA_W = 64
) (
    input  logic [31:0]       instr_i,
    output logic [REG_W-1:0]  ra_o,
    output logic [REG_W-1:0]  rb_o,
    output logic [REG_W-1:0]  rw_o,
    output logic [DATA_W-1:0] offset_o,
    output logic              op_mem_o,
    output logic              add_sub_o,
    output fd_kind_e          kind_o,
    output logic              illegal_o
);

    // Sign-extend a 12-bit immediate to the datapath width.
    function automatic logic [DATA_W-1:0] sext12(input logic [11:0] imm);
        return {{(DATA_W-12){imm[11]}}, imm};
    endfunction

    logic [REG_W-1:0] rs1_s;
    logic [REG_W-1:0] rs2_s;
    logic [REG_W-1:0] rd_s;
    logic [11:0]      imm_i_s;
    logic [11:0]      imm_s_s;

    assign rs1_s   = REG_W'(instr_i[19:15]);
    assign rs2_s   = REG_W'(instr_i[24:20]);
    assign rd_s    = REG_W'(instr_i[11:7]);
    assign imm_i_s = instr_i[31:20];
    assign imm_s_s = {instr_i[31:25], instr_i[11:7]};

    // Field selection per instruction class
    always_comb begin
        ra_o      = '0;
        rb_o      = '0;
        rw_o      = '0;
        offset_o  = '0;
        op_mem_o  = 1'b0;
        add_sub_o = 1'b0;
        kind_o    = classify(instr_i);
        case (kind_o)
            KIND_LD: begin
                ra_o     = rs1_s;
                rw_o     = rd_s;
                offset_o = sext12(imm_i_s);
                op_mem_o = 1'b1;
            end
            KIND_SD: begin
                ra_o     = rs1_s;
                rb_o     = rs2_s;
                offset_o = sext12(imm_s_s);
                op_mem_o = 1'b1;
            end
            KIND_ALU: begin
                ra_o      = rs1_s;
                rb_o      = rs2_s;
                rw_o      = rd_s;
                // funct7 bit 5 distinguishes sub from add
                add_sub_o = instr_i[30];
            end
            default: begin
                ra_o = '0;
            end
        endcase
        illegal_o = (kind_o == KIND_NONE);
    end

endmodule

// File: rtl/fd_control_unit.sv
// -----------------------------------------------------------------------------
// fd_control_unit
// Multi-cycle sequencer for the FD datapath. Accepts one ld/sd/add/sub per
// instr_valid/instr_ready handshake and walks it through
// IDLE -> DECODE -> [WAIT x MEM_WAIT] -> EXEC -> DONE -> IDLE, or
// IDLE -> DECODE -> ERR -> IDLE for unsupported encodings.
// Every output is a register loaded from the next-state logic, so output
// values line up with the state the FSM is in.
// Ports:
//   clk, rst_n                clock, synchronous active-low reset
//   instr, instr_valid        instruction offer
//   instr_ready               high only in IDLE
//   Ra, Rb, Rw, OFFSET        register addresses / sign-extended immediate
//   OP_MEM, ADD_SUB           result select / ALU op
//   WE_reg, WE_mem            single-cycle write strobes in EXEC
//   busy, done, illegal       status (done/illegal are 1-cycle pulses)
//   retired                   wrapping retired-instruction counter
// -----------------------------------------------------------------------------
module fd_control_unit
    import fd_control_unit_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int DATA_W   = 64,
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [REG_W-1:0]  Ra,
    output logic [REG_W-1:0]  Rb,
    output logic [REG_W-1:0]  Rw,
    output logic              WE_reg,
    output logic              WE_mem,
    output logic [DATA_W-1:0] OFFSET,
    output logic              OP_MEM,
    output logic              ADD_SUB,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [WAIT_CNT_W-1:0] MEM_WAIT_C = WAIT_CNT_W'(MEM_WAIT);

    // Decoder outputs
    logic [REG_W-1:0]  dec_ra_s;
    logic [REG_W-1:0]  dec_rb_s;
    logic [REG_W-1:0]  dec_rw_s;
    logic [DATA_W-1:0] dec_offset_s;
    logic              dec_op_mem_s;
    logic              dec_add_sub_s;
    fd_kind_e          dec_kind_s;
    logic              dec_illegal_s;

    // State and output registers
    fd_state_e         state_q,   state_d;
    fd_kind_e          kind_q,    kind_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [REG_W-1:0]  ra_q,      ra_d;
    logic [REG_W-1:0]  rb_q,      rb_d;
    logic [REG_W-1:0]  rw_q,      rw_d;
    logic [DATA_W-1:0] offset_q,  offset_d;
    logic              op_mem_q,  op_mem_d;
    logic              add_sub_q, add_sub_d;
    logic              we_reg_q,  we_reg_d;
    logic              we_mem_q,  we_mem_d;
    logic              done_q,    done_d;
    logic              illegal_q, illegal_d;
    logic              busy_q,    busy_d;
    logic              ready_q,   ready_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    // Strobe selection for the EXEC cycle; a write to x0 is dropped.
    logic              strobe_reg_s;
    logic              strobe_mem_s;

    fd_control_unit_instr_decoder #(
        .REG_W  (REG_W),
        .DATA_W (DATA_W)
    ) u_decoder (
        .instr_i   (instr),
        .ra_o      (dec_ra_s),
        .rb_o      (dec_rb_s),
        .rw_o      (dec_rw_s),
        .offset_o  (dec_offset_s),
        .op_mem_o  (dec_op_mem_s),
        .add_sub_o (dec_add_sub_s),
        .kind_o    (dec_kind_s),
        .illegal_o (dec_illegal_s)
    );

    assign strobe_reg_s = ((kind_q == KIND_LD) || (kind_q == KIND_ALU)) && (rw_q != '0);
    assign strobe_mem_s = (kind_q == KIND_SD);

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        rw_d      = rw_q;
        offset_d  = offset_q;
        op_mem_d  = op_mem_q;
        add_sub_d = add_sub_q;
        we_reg_d  = 1'b0;
        we_mem_d  = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        retired_d = retired_q;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    // Fields are captured on the accept edge so they are
                    // already valid during DECODE.
                    state_d   = ST_DECODE;
                    kind_d    = dec_kind_s;
                    ra_d      = dec_ra_s;
                    rb_d      = dec_rb_s;
                    rw_d      = dec_rw_s;
                    offset_d  = dec_offset_s;
                    op_mem_d  = dec_op_mem_s;
                    add_sub_d = dec_add_sub_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (kind_q == KIND_NONE) begin
                    state_d   = ST_ERR;
                    illegal_d = 1'b1;
                end else if ((kind_q != KIND_ALU) && (MEM_WAIT_C != '0)) begin
                    state_d = ST_WAIT;
                    cnt_d   = MEM_WAIT_C;
                end else begin
                    state_d  = ST_EXEC;
                    we_reg_d = strobe_reg_s;
                    we_mem_d = strobe_mem_s;
                end
            end
            ST_WAIT: begin
                // The counter holds the cycles still to spend in WAIT,
                // including the current one.
                if (cnt_q <= WAIT_CNT_W'(1)) begin
                    state_d  = ST_EXEC;
                    cnt_d    = '0;
                    we_reg_d = strobe_reg_s;
                    we_mem_d = strobe_mem_s;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            ST_EXEC: begin
                state_d   = ST_DONE;
                done_d    = 1'b1;
                retired_d = retired_q + CNT_W'(1);
            end
            ST_DONE, ST_ERR: begin
                state_d   = ST_IDLE;
                kind_d    = KIND_NONE;
                ra_d      = '0;
                rb_d      = '0;
                rw_d      = '0;
                offset_d  = '0;
                op_mem_d  = 1'b0;
                add_sub_d = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                kind_d    = KIND_NONE;
                cnt_d     = '0;
                ra_d      = '0;
                rb_d      = '0;
                rw_d      = '0;
                offset_d  = '0;
                op_mem_d  = 1'b0;
                add_sub_d = 1'b0;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            kind_q    <= KIND_NONE;
            cnt_q     <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rw_q      <= '0;
            offset_q  <= '0;
            op_mem_q  <= 1'b0;
            add_sub_q <= 1'b0;
            we_reg_q  <= 1'b0;
            we_mem_q  <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cnt_q     <= cnt_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            rw_q      <= rw_d;
            offset_q  <= offset_d;
            op_mem_q  <= op_mem_d;
            add_sub_q <= add_sub_d;
            we_reg_q  <= we_reg_d;
            we_mem_q  <= we_mem_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            retired_q <= retired_d;
        end
    end

    assign instr_ready = ready_q;
    assign Ra          = ra_q;
    assign Rb          = rb_q;
    assign Rw          = rw_q;
    assign WE_reg      = we_reg_q;
    assign WE_mem      = we_mem_q;
    assign OFFSET      = offset_q;
    assign OP_MEM      = op_mem_q;
    assign ADD_SUB     = add_sub_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_fd_control_unit.sv
// -----------------------------------------------------------------------------
// tb_fd_control_unit
// Directed bench for fd_control_unit (MEM_WAIT=1) driving a small behavioural
// FD datapath (32x64 register bank, 16-word data memory, add/sub ALU) with
// Mem[1]=10 and Mem[2]=20. Cycle numbers count negedges after the accept edge.
// -----------------------------------------------------------------------------
module tb_fd_control_unit;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 64;
    localparam int MEM_WAIT = 1;
    localparam int CNT_W    = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [REG_W-1:0]  Ra, Rb, Rw;
    logic              WE_reg, WE_mem;
    logic [DATA_W-1:0] OFFSET;
    logic              OP_MEM, ADD_SUB;
    logic              busy, done, illegal;
    logic [CNT_W-1:0]  retired;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fd_control_unit #(
        .REG_W(REG_W), .DATA_W(DATA_W), .MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .Ra(Ra), .Rb(Rb), .Rw(Rw),
        .WE_reg(WE_reg), .WE_mem(WE_mem), .OFFSET(OFFSET), .OP_MEM(OP_MEM),
        .ADD_SUB(ADD_SUB), .busy(busy), .done(done), .illegal(illegal),
        .retired(retired)
    );

    // Behavioural FD datapath
    logic [63:0] regs [32];
    logic [63:0] mem  [16];
    logic        tb_init = 1'b1;
    logic [63:0] ea_s;
    assign ea_s = regs[Ra] + OFFSET;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 32; i++) regs[i] <= 64'd0;
            for (int i = 0; i < 16; i++) mem[i] <= 64'd0;
            mem[1] <= 64'd10;
            mem[2] <= 64'd20;
        end else begin
            if (WE_reg && (Rw != 5'd0))
                regs[Rw] <= OP_MEM ? mem[ea_s[3:0]]
                          : (ADD_SUB ? regs[Ra] - regs[Rb] : regs[Ra] + regs[Rb]);
            if (WE_mem)
                mem[ea_s[3:0]] <= regs[Rb];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Results of the last run_instr
    logic [REG_W-1:0]  f_ra, f_rb, f_rw;
    logic [DATA_W-1:0] f_off;
    logic              f_opm, f_as, f_we1;
    int c_wer, c_wem, c_done, c_ill, c_rdy, n_wer, n_wem;
    logic [CNT_W-1:0]  r_ret;

    task automatic wait_ready(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (instr_ready) got = 1'b1;
        end
        chk({tag, ".ready_wait"}, 64'(got), 64'd1);
    endtask

    task automatic run_instr(input string tag, input logic [31:0] w);
        wait_ready(tag);
        instr = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        c_wer = -1; c_wem = -1; c_done = -1; c_ill = -1; c_rdy = -1;
        n_wer = 0; n_wem = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                f_ra = Ra; f_rb = Rb; f_rw = Rw; f_off = OFFSET;
                f_opm = OP_MEM; f_as = ADD_SUB; f_we1 = WE_reg | WE_mem;
            end
            if (WE_reg) begin n_wer++; if (c_wer < 0) c_wer = cyc; end
            if (WE_mem) begin n_wem++; if (c_wem < 0) c_wem = cyc; end
            if (done    && c_done < 0) c_done = cyc;
            if (illegal && c_ill  < 0) c_ill  = cyc;
            if (instr_ready) begin
                c_rdy = cyc;
                r_ret = retired;
                break;
            end
        end
    endtask

    task automatic chk_fields(input string tag, input int ra, input int rb, input int rw,
                              input logic [63:0] off, input int opm, input int as_);
        chk({tag, ".Ra"},      64'(f_ra),  64'(ra));
        chk({tag, ".Rb"},      64'(f_rb),  64'(rb));
        chk({tag, ".Rw"},      64'(f_rw),  64'(rw));
        chk({tag, ".OFFSET"},  f_off,      off);
        chk({tag, ".OP_MEM"},  64'(f_opm), 64'(opm));
        chk({tag, ".ADD_SUB"}, 64'(f_as),  64'(as_));
        chk({tag, ".we_decode"}, 64'(f_we1), 64'd0);
    endtask

    task automatic chk_timing(input string tag, input int wer, input int wem,
                              input int dn, input int ill, input int rdy, input int ret);
        chk({tag, ".we_reg_cyc"},  64'(c_wer),  64'(wer));
        chk({tag, ".we_reg_cnt"},  64'(n_wer),  64'((wer < 0) ? 0 : 1));
        chk({tag, ".we_mem_cyc"},  64'(c_wem),  64'(wem));
        chk({tag, ".we_mem_cnt"},  64'(n_wem),  64'((wem < 0) ? 0 : 1));
        chk({tag, ".done_cyc"},    64'(c_done), 64'(dn));
        chk({tag, ".illegal_cyc"}, 64'(c_ill),  64'(ill));
        chk({tag, ".ready_cyc"},   64'(c_rdy),  64'(rdy));
        chk({tag, ".retired"},     64'(r_ret),  64'(ret));
    endtask

    initial begin
        logic [5:0] ill_m, rdy_m, stb_m, done_m;
        bit seen;

        rst_n = 1'b0; instr = 32'd0; instr_valid = 1'b0;
        @(posedge clk);
        #1 tb_init = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst.ready",   64'(instr_ready), 64'd1);
        chk("rst.busy",    64'(busy),        64'd0);
        chk("rst.strobes", 64'({WE_reg, WE_mem, done, illegal}), 64'd0);
        chk("rst.retired", 64'(retired),     64'd0);
        rst_n = 1'b1;

        // Reset in the EXEC cycle of a load
        wait_ready("mid");
        instr = 32'h00103083; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        seen = 1'b0;
        for (int cyc = 1; cyc <= 6 && !seen; cyc++) begin
            @(negedge clk);
            if (WE_reg) begin
                seen = 1'b1;
                chk("mid.we_cyc", 64'(cyc), 64'd3);
            end
        end
        chk("mid.we_seen", 64'(seen), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid.WE_reg",  64'(WE_reg),      64'd0);
        chk("mid.fields",  64'({Ra, Rb, Rw, OP_MEM, ADD_SUB}), 64'd0);
        chk("mid.OFFSET",  OFFSET,           64'd0);
        chk("mid.retired", 64'(retired),     64'd0);
        chk("mid.ready",   64'(instr_ready), 64'd1);
        chk("mid.busy",    64'(busy),        64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid.no_done", 64'(done), 64'd0);

        run_instr("ld1", 32'h00103083);
        chk_fields("ld1", 0, 0, 1, 64'd1, 1, 0);
        chk_timing("ld1", 3, -1, 4, -1, 5, 1);
        chk("ld1.reg1", regs[1], 64'd10);

        run_instr("ld2", 32'h00203103);
        chk_timing("ld2", 3, -1, 4, -1, 5, 2);
        chk("ld2.reg2", regs[2], 64'd20);

        run_instr("add", 32'h001101B3);
        chk_fields("add", 2, 1, 3, 64'd0, 0, 0);
        chk_timing("add", 2, -1, 3, -1, 4, 3);
        chk("add.reg3", regs[3], 64'd30);

        run_instr("sub", 32'h40118233);
        chk_fields("sub", 3, 1, 4, 64'd0, 0, 1);
        chk_timing("sub", 2, -1, 3, -1, 4, 4);
        chk("sub.reg4", regs[4], 64'd20);

        run_instr("sd", 32'h00403223);
        chk_fields("sd", 0, 4, 0, 64'd4, 1, 0);
        chk_timing("sd", -1, 3, 4, -1, 5, 5);
        chk("sd.mem4", mem[4], 64'd20);

        run_instr("ldneg", 32'hFF813283);
        chk_fields("ldneg", 2, 0, 5, 64'hFFFF_FFFF_FFFF_FFF8, 1, 0);
        chk_timing("ldneg", 3, -1, 4, -1, 5, 6);
        chk("ldneg.reg5", regs[5], 64'd0);

        run_instr("ldx0", 32'h00103003);
        chk_fields("ldx0", 0, 0, 0, 64'd1, 1, 0);
        chk_timing("ldx0", -1, -1, 4, -1, 5, 7);

        // Illegal word with instr_valid held high across the busy period
        wait_ready("ill");
        instr = 32'h00000000; instr_valid = 1'b1;
        @(posedge clk);
        ill_m = 6'd0; rdy_m = 6'd0; stb_m = 6'd0; done_m = 6'd0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            ill_m[cyc-1]  = illegal;
            rdy_m[cyc-1]  = instr_ready;
            stb_m[cyc-1]  = WE_reg | WE_mem;
            done_m[cyc-1] = done;
            if (cyc == 1) chk("ill.fields", 64'({Ra, Rb, Rw, OP_MEM, ADD_SUB}), 64'd0);
        end
        instr_valid = 1'b0;
        chk("ill.illegal_mask", 64'(ill_m),  64'(6'b010010));
        chk("ill.ready_mask",   64'(rdy_m),  64'(6'b100100));
        chk("ill.strobe_mask",  64'(stb_m),  64'd0);
        chk("ill.done_mask",    64'(done_m), 64'd0);
        chk("ill.retired",      64'(retired), 64'd7);
        @(negedge clk);
        chk("ill.idle_busy",    64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
